// File: rtl/pipe_barrel_shifter_if.sv
// Handshake bundle for pipe_barrel_shifter.
//
// Carries the operand side (in_valid/in_ready/in_data/in_cnt/in_op), the
// result side (out_valid/out_ready/out_data) and the pipeline flush.
// When PIPE_SHIFTER_FLAGS_EN is defined the result side also carries
// out_zero and out_cout.
//
// Modports:
//   master - the producer/consumer around the shifter (drives operands,
//            flush and out_ready; observes in_ready and the result).
//   slave  - the shifter itself.
interface pipe_barrel_shifter_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH)
);

   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [CNT_W-1:0] in_cnt;
   logic [1:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
`ifdef PIPE_SHIFTER_FLAGS_EN
   logic             out_zero;
   logic             out_cout;

   modport master (
      output flush, in_valid, in_data, in_cnt, in_op, out_ready,
      input  in_ready, out_valid, out_data, out_zero, out_cout
   );

   modport slave (
      input  flush, in_valid, in_data, in_cnt, in_op, out_ready,
      output in_ready, out_valid, out_data, out_zero, out_cout
   );
`else
   modport master (
      output flush, in_valid, in_data, in_cnt, in_op, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  flush, in_valid, in_data, in_cnt, in_op, out_ready,
      output in_ready, out_valid, out_data
   );
`endif

endinterface

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter with an elastic valid/ready pipeline.
//
// Four operations selected by in_op: 00 ROL, 01 SLL, 10 ROR, 11 SRA.
// The log2(WIDTH) mux levels are spread over PIPE_STAGES register stages;
// level k (shift by 2^k) lives in stage (k*PIPE_STAGES)/LEVELS.
// Latency is PIPE_STAGES cycles and throughput is one result per cycle.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset (clears valids and out_data)
//   bus  - pipe_barrel_shifter_if.slave: flush, in_* operand handshake,
//          out_* result handshake
//
// Optional feature: define PIPE_SHIFTER_FLAGS_EN to add out_zero and
// out_cout on the interface, travelling alongside each result.
module pipe_barrel_shifter #(
   parameter int WIDTH       = 16,
   parameter int PIPE_STAGES = 2,
   parameter int CNT_W       = $clog2(WIDTH)
) (
   input logic                    clk,
   input logic                    rst,
   pipe_barrel_shifter_if.slave   bus
);

   localparam int LEVELS = CNT_W;

   // Stage registers. The whole shift count rides along so each stage can
   // pick the count bits belonging to its own levels.
   logic [WIDTH-1:0]       data_q  [PIPE_STAGES];
   logic [WIDTH-1:0]       data_d  [PIPE_STAGES];
   logic [CNT_W-1:0]       cnt_q   [PIPE_STAGES];
   logic [CNT_W-1:0]       cnt_d   [PIPE_STAGES];
   logic [1:0]             op_q    [PIPE_STAGES];
   logic [1:0]             op_d    [PIPE_STAGES];
   logic                   msb_q   [PIPE_STAGES];
   logic                   msb_d   [PIPE_STAGES];
   logic [PIPE_STAGES-1:0] valid_q;
   logic [PIPE_STAGES-1:0] valid_d;
   logic [PIPE_STAGES-1:0] adv;
   logic                   in_ready_int;

`ifdef PIPE_SHIFTER_FLAGS_EN
   localparam logic [1:0] OP_ROL = 2'b00;
   localparam logic [1:0] OP_SLL = 2'b01;
   localparam logic [1:0] OP_ROR = 2'b10;

   logic cbit_q [PIPE_STAGES];
   logic cbit_d [PIPE_STAGES];
   logic zero_q;
   logic zero_d;
   logic cout_q;
   logic cout_d;
`endif

   // One mux level: op[1] chooses the left or right source, op[0] chooses
   // between wrap-around fill (rotates) and 0/sign fill (SLL/SRA).
   function automatic logic [WIDTH-1:0] shift_level(
      input logic [WIDTH-1:0] d,
      input int               amt,
      input logic [1:0]       op,
      input logic             msb
   );
      logic [WIDTH-1:0] left_src;
      logic [WIDTH-1:0] right_src;
      logic [WIDTH-1:0] sign_fill;
      sign_fill = msb ? ~({WIDTH{1'b1}} >> amt) : '0;
      left_src  = (d << amt) | (op[0] ? '0 : (d >> (WIDTH - amt)));
      right_src = (d >> amt) | (op[0] ? sign_fill : (d << (WIDTH - amt)));
      return op[1] ? right_src : left_src;
   endfunction

   // Apply every level assigned to the given stage, lowest level first.
   function automatic logic [WIDTH-1:0] apply_levels(
      input logic [WIDTH-1:0] d,
      input int               stage,
      input logic [CNT_W-1:0] cnt,
      input logic [1:0]       op,
      input logic             msb
   );
      logic [WIDTH-1:0] res;
      res = d;
      for (int k = 0; k < LEVELS; k++) begin
         if ((((k * PIPE_STAGES) / LEVELS) == stage) && cnt[k]) begin
            res = shift_level(res, 1 << k, op, msb);
         end
      end
      return res;
   endfunction

   // Backpressure chain, from the output back to the input. A stage may
   // take new contents when it is empty or when its occupant moves on, so
   // in_ready is combinational from out_ready. The next-state of each
   // stage is then its predecessor's contents pushed through its levels.
   always_comb begin
      adv[PIPE_STAGES-1] = !valid_q[PIPE_STAGES-1] | bus.out_ready;
      for (int s = PIPE_STAGES - 2; s >= 0; s--) begin
         adv[s] = !valid_q[s] | adv[s+1];
      end
      in_ready_int = !rst & !bus.flush & adv[0];

      valid_d[0] = bus.in_valid & in_ready_int;
      cnt_d[0]   = bus.in_cnt;
      op_d[0]    = bus.in_op;
      msb_d[0]   = bus.in_data[WIDTH-1];
      data_d[0]  = apply_levels(bus.in_data, 0, bus.in_cnt, bus.in_op,
                                bus.in_data[WIDTH-1]);
      for (int s = 1; s < PIPE_STAGES; s++) begin
         valid_d[s] = valid_q[s-1];
         cnt_d[s]   = cnt_q[s-1];
         op_d[s]    = op_q[s-1];
         msb_d[s]   = msb_q[s-1];
         data_d[s]  = apply_levels(data_q[s-1], s, cnt_q[s-1], op_q[s-1],
                                   msb_q[s-1]);
      end
   end

`ifdef PIPE_SHIFTER_FLAGS_EN
   // SLL and SRA carry-outs come from the original operand, so the bit is
   // picked at the input and carried down. 0-c wraps to WIDTH-c. Rotate
   // carry-outs and the zero flag come from the final shifted value.
   always_comb begin
      cbit_d[0] = (bus.in_op == OP_SLL) ? bus.in_data[CNT_W'(0) - bus.in_cnt]
                                        : bus.in_data[bus.in_cnt - CNT_W'(1)];
      for (int s = 1; s < PIPE_STAGES; s++) begin
         cbit_d[s] = cbit_q[s-1];
      end
      zero_d = (data_d[PIPE_STAGES-1] == '0);
      if (cnt_d[PIPE_STAGES-1] == '0) begin
         cout_d = 1'b0;
      end else if (op_d[PIPE_STAGES-1] == OP_ROL) begin
         cout_d = data_d[PIPE_STAGES-1][0];
      end else if (op_d[PIPE_STAGES-1] == OP_ROR) begin
         cout_d = data_d[PIPE_STAGES-1][WIDTH-1];
      end else begin
         cout_d = cbit_d[PIPE_STAGES-1];
      end
   end

   // Flags share the last stage's load enable and reset; flush only drops
   // the valid bit, so the flags simply hold like out_data does.
   always_ff @(posedge clk) begin
      if (rst) begin
         zero_q <= 1'b0;
         cout_q <= 1'b0;
      end else if (!bus.flush) begin
         for (int s = 0; s < PIPE_STAGES; s++) begin
            if (adv[s] && valid_d[s]) begin
               cbit_q[s] <= cbit_d[s];
            end
         end
         if (adv[PIPE_STAGES-1] && valid_d[PIPE_STAGES-1]) begin
            zero_q <= zero_d;
            cout_q <= cout_d;
         end
      end
   end

   assign bus.out_zero = zero_q;
   assign bus.out_cout = cout_q;
`endif

   // Pipeline registers. Reset beats flush; both only clear valid bits,
   // except that reset also zeroes the visible result. Payload loads only
   // when a valid operation moves in, so an empty output holds its value.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q                <= '0;
         data_q[PIPE_STAGES-1]  <= '0;
      end else if (bus.flush) begin
         valid_q <= '0;
      end else begin
         for (int s = 0; s < PIPE_STAGES; s++) begin
            if (adv[s]) begin
               valid_q[s] <= valid_d[s];
               if (valid_d[s]) begin
                  data_q[s] <= data_d[s];
                  cnt_q[s]  <= cnt_d[s];
                  op_q[s]   <= op_d[s];
                  msb_q[s]  <= msb_d[s];
               end
            end
         end
      end
   end

   assign bus.in_ready  = in_ready_int;
   assign bus.out_valid = valid_q[PIPE_STAGES-1];
   assign bus.out_data  = data_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Directed testbench for pipe_barrel_shifter at WIDTH=16, PIPE_STAGES=2.
// Inputs are driven on the falling edge and outputs are sampled there too,
// half a cycle away from the rising edge where the DUT updates.
// Flag checks are compiled in when PIPE_SHIFTER_FLAGS_EN is defined.
module tb_pipe_barrel_shifter;

   localparam logic [1:0] OP_ROL = 2'b00;
   localparam logic [1:0] OP_SLL = 2'b01;
   localparam logic [1:0] OP_ROR = 2'b10;
   localparam logic [1:0] OP_SRA = 2'b11;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   pipe_barrel_shifter_if #(.WIDTH(16)) bus ();

   pipe_barrel_shifter #(
      .WIDTH       (16),
      .PIPE_STAGES (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the run ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Drive the operand side of the interface.
   task automatic applyStimulus(input logic v, input logic [1:0] op,
                                input logic [15:0] d, input logic [3:0] c);
      bus.in_valid = v;
      bus.in_op    = op;
      bus.in_data  = d;
      bus.in_cnt   = c;
   endtask

   // Reset in progress, then released with an empty pipe.
   task automatic test_reset;
      rst           = 1'b1;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      applyStimulus(1'b1, OP_SLL, 16'h0001, 4'd1);
      @(negedge clk);
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_in_ready: got %b want 0", bus.in_ready);
      end
      total++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000) begin
         bad++;
         $display("[TB] FAIL reset_out: got v=%b d=%h want v=0 d=0000",
                  bus.out_valid, bus.out_data);
      end
      applyStimulus(1'b0, OP_SLL, 16'h0000, 4'd0);
      rst = 1'b0;
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL reset_release_ready: got %b want 1", bus.in_ready);
      end
   endtask

   // Four different ops at one per cycle; each result two cycles later.
   task automatic test_back_to_back;
      logic [1:0]  ops [4];
      logic [15:0] din [4];
      logic [3:0]  cnt [4];
      logic [15:0] exp_d [4];
      logic        exp_c [4];
      ops[0] = OP_SLL; din[0] = 16'h8001; cnt[0] = 4'd1;  exp_d[0] = 16'h0002; exp_c[0] = 1'b1;
      ops[1] = OP_SRA; din[1] = 16'h8000; cnt[1] = 4'd15; exp_d[1] = 16'hFFFF; exp_c[1] = 1'b0;
      ops[2] = OP_ROR; din[2] = 16'h0001; cnt[2] = 4'd4;  exp_d[2] = 16'h1000; exp_c[2] = 1'b0;
      ops[3] = OP_ROL; din[3] = 16'h1234; cnt[3] = 4'd4;  exp_d[3] = 16'h2341; exp_c[3] = 1'b1;
      bus.out_ready = 1'b1;
      for (int cyc = 0; cyc < 7; cyc++) begin
         @(negedge clk);
         if (cyc >= 2 && cyc <= 5) begin
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d[cyc-2]) begin
               bad++;
               $display("[TB] FAIL b2b_result%0d: got v=%b d=%h want v=1 d=%h",
                        cyc - 2, bus.out_valid, bus.out_data, exp_d[cyc-2]);
            end
`ifdef PIPE_SHIFTER_FLAGS_EN
            total++;
            if (bus.out_cout !== exp_c[cyc-2] || bus.out_zero !== 1'b0) begin
               bad++;
               $display("[TB] FAIL b2b_flags%0d: got c=%b z=%b want c=%b z=0",
                        cyc - 2, bus.out_cout, bus.out_zero, exp_c[cyc-2]);
            end
`endif
         end else begin
            total++;
            if (bus.out_valid !== 1'b0) begin
               bad++;
               $display("[TB] FAIL b2b_idle_c%0d: got out_valid=%b want 0",
                        cyc, bus.out_valid);
            end
         end
         if (cyc < 4) begin
            applyStimulus(1'b1, ops[cyc], din[cyc], cnt[cyc]);
            #1;
            total++;
            if (bus.in_ready !== 1'b1) begin
               bad++;
               $display("[TB] FAIL b2b_ready%0d: got %b want 1", cyc, bus.in_ready);
            end
         end else begin
            applyStimulus(1'b0, OP_SLL, 16'h0000, 4'd0);
         end
      end
   endtask

   // A zero count leaves the operand untouched for every op.
   task automatic test_passthrough;
      logic [1:0] ops [4];
      ops[0] = OP_ROL; ops[1] = OP_SLL; ops[2] = OP_ROR; ops[3] = OP_SRA;
      bus.out_ready = 1'b1;
      for (int cyc = 0; cyc < 7; cyc++) begin
         @(negedge clk);
         if (cyc >= 2 && cyc <= 5) begin
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hA5C3) begin
               bad++;
               $display("[TB] FAIL pass_op%0d: got v=%b d=%h want v=1 d=a5c3",
                        cyc - 2, bus.out_valid, bus.out_data);
            end
`ifdef PIPE_SHIFTER_FLAGS_EN
            total++;
            if (bus.out_cout !== 1'b0 || bus.out_zero !== 1'b0) begin
               bad++;
               $display("[TB] FAIL pass_flags%0d: got c=%b z=%b want c=0 z=0",
                        cyc - 2, bus.out_cout, bus.out_zero);
            end
`endif
         end
         if (cyc < 4) applyStimulus(1'b1, ops[cyc], 16'hA5C3, 4'd0);
         else         applyStimulus(1'b0, OP_SLL, 16'h0000, 4'd0);
      end
   endtask

   // Stall the output: two ops fill the pipe, then the head is held until
   // out_ready returns and everything drains in order.
   task automatic test_backpressure;
      logic [15:0] exp_d [4];
      exp_d[0] = 16'h0001; exp_d[1] = 16'h0002; exp_d[2] = 16'h0004; exp_d[3] = 16'h0008;
      bus.out_ready = 1'b0;
      @(negedge clk);
      applyStimulus(1'b1, OP_SLL, 16'h0001, 4'd0);
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL bp_accept0: got in_ready=%b want 1", bus.in_ready);
      end
      @(negedge clk);
      applyStimulus(1'b1, OP_SLL, 16'h0001, 4'd1);
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL bp_accept1: got in_ready=%b want 1", bus.in_ready);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         applyStimulus(1'b1, OP_SLL, 16'h0001, 4'd2);
         #1;
         total++;
         if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bp_full%0d: got in_ready=%b want 0", i, bus.in_ready);
         end
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0001) begin
            bad++;
            $display("[TB] FAIL bp_hold%0d: got v=%b d=%h want v=1 d=0001",
                     i, bus.out_valid, bus.out_data);
         end
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i < 4) begin
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d[i]) begin
               bad++;
               $display("[TB] FAIL bp_drain%0d: got v=%b d=%h want v=1 d=%h",
                        i, bus.out_valid, bus.out_data, exp_d[i]);
            end
         end else begin
            total++;
            if (bus.out_valid !== 1'b0) begin
               bad++;
               $display("[TB] FAIL bp_empty: got out_valid=%b want 0", bus.out_valid);
            end
         end
         bus.out_ready = 1'b1;
         if (i == 0)      applyStimulus(1'b1, OP_SLL, 16'h0001, 4'd2);
         else if (i == 1) applyStimulus(1'b1, OP_SLL, 16'h0001, 4'd3);
         else             applyStimulus(1'b0, OP_SLL, 16'h0000, 4'd0);
      end
   endtask

   // Flush with two ops in flight and a third presented in the same cycle.
   task automatic test_flush;
      bus.out_ready = 1'b1;
      @(negedge clk);
      applyStimulus(1'b1, OP_SLL, 16'h0001, 4'd1);
      @(negedge clk);
      applyStimulus(1'b1, OP_SLL, 16'h0001, 4'd2);
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0002) begin
         bad++;
         $display("[TB] FAIL flush_pre: got v=%b d=%h want v=1 d=0002",
                  bus.out_valid, bus.out_data);
      end
      bus.flush = 1'b1;
      applyStimulus(1'b1, OP_SLL, 16'h0007, 4'd0);
      #1;
      total++;
      if (bus.in_ready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL flush_ready: got %b want 0", bus.in_ready);
      end
      @(negedge clk);
      bus.flush = 1'b0;
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL flush_clear: got out_valid=%b want 0", bus.out_valid);
      end
      applyStimulus(1'b1, OP_SRA, 16'h4000, 4'd2);
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL flush_after_ready: got %b want 1", bus.in_ready);
      end
      @(negedge clk);
      applyStimulus(1'b0, OP_SLL, 16'h0000, 4'd0);
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL flush_dropped: got out_valid=%b want 0", bus.out_valid);
      end
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h1000) begin
         bad++;
         $display("[TB] FAIL flush_new: got v=%b d=%h want v=1 d=1000",
                  bus.out_valid, bus.out_data);
      end
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL flush_tail: got out_valid=%b want 0", bus.out_valid);
      end
   endtask

   // Reset with two ops in flight: nothing may appear until a new op.
   task automatic test_reset_midflight;
      bus.out_ready = 1'b1;
      @(negedge clk);
      applyStimulus(1'b1, OP_SLL, 16'h0003, 4'd2);
      @(negedge clk);
      applyStimulus(1'b1, OP_SLL, 16'h0003, 4'd3);
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h000C) begin
         bad++;
         $display("[TB] FAIL rst_pre: got v=%b d=%h want v=1 d=000c",
                  bus.out_valid, bus.out_data);
      end
      rst = 1'b1;
      applyStimulus(1'b1, OP_SLL, 16'h0003, 4'd4);
      #1;
      total++;
      if (bus.in_ready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL rst_mid_ready: got %b want 0", bus.in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, OP_SLL, 16'h0000, 4'd0);
      total++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000) begin
         bad++;
         $display("[TB] FAIL rst_mid_out: got v=%b d=%h want v=0 d=0000",
                  bus.out_valid, bus.out_data);
      end
`ifdef PIPE_SHIFTER_FLAGS_EN
      total++;
      if (bus.out_cout !== 1'b0 || bus.out_zero !== 1'b0) begin
         bad++;
         $display("[TB] FAIL rst_mid_flags: got c=%b z=%b want c=0 z=0",
                  bus.out_cout, bus.out_zero);
      end
`endif
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total++;
         if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_mid_quiet%0d: got out_valid=%b want 0",
                     i, bus.out_valid);
         end
      end
      applyStimulus(1'b1, OP_ROL, 16'h00F0, 4'd4);
      @(negedge clk);
      applyStimulus(1'b0, OP_SLL, 16'h0000, 4'd0);
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0F00) begin
         bad++;
         $display("[TB] FAIL rst_mid_new: got v=%b d=%h want v=1 d=0f00",
                  bus.out_valid, bus.out_data);
      end
      @(negedge clk);
   endtask

`ifdef PIPE_SHIFTER_FLAGS_EN
   // Zero result with a carry out of the top, and an SRA carry out of bit 0.
   task automatic test_flags;
      bus.out_ready = 1'b1;
      @(negedge clk);
      applyStimulus(1'b1, OP_SLL, 16'h8000, 4'd1);
      @(negedge clk);
      applyStimulus(1'b1, OP_SRA, 16'h0003, 4'd1);
      @(negedge clk);
      applyStimulus(1'b0, OP_SLL, 16'h0000, 4'd0);
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0000 ||
          bus.out_zero !== 1'b1 || bus.out_cout !== 1'b1) begin
         bad++;
         $display("[TB] FAIL flags_sll: got v=%b d=%h z=%b c=%b want v=1 d=0000 z=1 c=1",
                  bus.out_valid, bus.out_data, bus.out_zero, bus.out_cout);
      end
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0001 ||
          bus.out_zero !== 1'b0 || bus.out_cout !== 1'b1) begin
         bad++;
         $display("[TB] FAIL flags_sra: got v=%b d=%h z=%b c=%b want v=1 d=0001 z=0 c=1",
                  bus.out_valid, bus.out_data, bus.out_zero, bus.out_cout);
      end
      @(negedge clk);
   endtask
`endif

   // Scenario sequence.
   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_back_to_back();
      test_passthrough();
      test_backpressure();
      test_flush();
      test_reset_midflight();
`ifdef PIPE_SHIFTER_FLAGS_EN
      test_flags();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
